// File: rtl/runner_pkg.sv
// runner_pkg: event priority encoding, default parameters and runs_play width shared by the tracker
package runner_pkg;
  localparam int NUM_BASES_DEF = 3;
  localparam int BALLS_PER_WALK_DEF = 4;
  localparam int OUTS_PER_INNING_DEF = 3;
  localparam int RUN_W_DEF = 8;
  localparam int RUNS_PLAY_W = 3;
  typedef enum logic [2:0] {
    EV_NONE, EV_BALL, EV_OUT, EV_SINGLE, EV_DOUBLE, EV_TRIPLE, EV_HOMERUN
  } event_e;
endpackage

// File: rtl/base_advance.sv
// base_advance: combinational runner advance; occ_in/adv/force_mode -> occ_out and runs scored (adv>NUM_BASES clears bases)
module base_advance import runner_pkg::*; #(
  parameter int NUM_BASES = NUM_BASES_DEF
) (
  input  logic [NUM_BASES-1:0]   occ_in,
  input  logic [3:0]             adv,
  input  logic                   force_mode,
  output logic [NUM_BASES-1:0]   occ_out,
  output logic [RUNS_PLAY_W-1:0] runs
);
  logic [NUM_BASES+8:0] sh;
  logic [NUM_BASES-1:0] forced;
  logic fill;
  logic [3:0] cnt;
  always_comb begin
    sh = {8'd0, occ_in, 1'b1} << adv;
    cnt = 4'd0;
    for (int i = NUM_BASES + 1; i <= NUM_BASES + 8; i++) cnt = cnt + {3'd0, sh[i]};
    fill = 1'b1;
    forced = '0;
    for (int i = 0; i < NUM_BASES; i++) begin
      forced[i] = occ_in[i] | fill;
      fill = fill & occ_in[i];
    end
    occ_out = force_mode ? forced : sh[NUM_BASES:1];
    runs = force_mode ? RUNS_PLAY_W'(fill) : (cnt > 4'd7 ? '1 : cnt[RUNS_PLAY_W-1:0]);
  end
endmodule

// File: rtl/base_runner_tracker.sv
// base_runner_tracker: registered base/ball/out/run tracker; in: ball, single, double, triple, homerun, out_evt; out: runner, ball_cnt, out_cnt, runs_total, runs_play, walk_p, inning_end_p
module base_runner_tracker import runner_pkg::*; #(
  parameter int NUM_BASES = NUM_BASES_DEF,
  parameter int BALLS_PER_WALK = BALLS_PER_WALK_DEF,
  parameter int OUTS_PER_INNING = OUTS_PER_INNING_DEF,
  parameter int RUN_W = RUN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ball,
  input  logic                   single,
  input  logic                   double,
  input  logic                   triple,
  input  logic                   homerun,
  input  logic                   out_evt,
  output logic [NUM_BASES-1:0]   runner,
  output logic [2:0]             ball_cnt,
  output logic [2:0]             out_cnt,
  output logic [RUN_W-1:0]       runs_total,
  output logic [RUNS_PLAY_W-1:0] runs_play,
  output logic                   walk_p,
  output logic                   inning_end_p
);
  event_e ev;
  logic [3:0] adv;
  logic [2:0] ball_nxt, out_nxt;
  logic walk, inning_end, moved;
  logic [NUM_BASES-1:0] adv_occ;
  logic [RUNS_PLAY_W-1:0] adv_runs;
  logic [RUN_W:0] sum;
  logic [NUM_BASES-1:0] runner_q, runner_d;
  logic [2:0] ball_cnt_q, ball_cnt_d, out_cnt_q, out_cnt_d;
  logic [RUN_W-1:0] runs_total_q, runs_total_d;
  logic [RUNS_PLAY_W-1:0] runs_play_q, runs_play_d;
  logic walk_q, walk_d, inning_end_q, inning_end_d;
  base_advance #(.NUM_BASES(NUM_BASES)) u_adv (
    .occ_in(runner_q), .adv(adv), .force_mode(walk), .occ_out(adv_occ), .runs(adv_runs)
  );
  always_comb begin
    ev = homerun ? EV_HOMERUN : triple ? EV_TRIPLE : double ? EV_DOUBLE :
         single ? EV_SINGLE : out_evt ? EV_OUT : ball ? EV_BALL : EV_NONE;
    adv = ev == EV_HOMERUN ? 4'(NUM_BASES + 1) : ev == EV_TRIPLE ? 4'd3 :
          ev == EV_DOUBLE ? 4'd2 : ev == EV_SINGLE ? 4'd1 : 4'd0;
    ball_nxt = ball_cnt_q + 3'd1;
    out_nxt = out_cnt_q + 3'd1;
    walk = ev == EV_BALL && ball_nxt == 3'(BALLS_PER_WALK);
    inning_end = ev == EV_OUT && out_nxt == 3'(OUTS_PER_INNING);
    moved = adv != 4'd0 || walk;
    runner_d = inning_end ? '0 : moved ? adv_occ : runner_q;
    ball_cnt_d = (ev == EV_BALL && !walk) ? ball_nxt : ev == EV_NONE ? ball_cnt_q : 3'd0;
    out_cnt_d = ev == EV_OUT ? (inning_end ? 3'd0 : out_nxt) : out_cnt_q;
    runs_play_d = moved ? adv_runs : '0;
    sum = {1'b0, runs_total_q} + (RUN_W + 1)'(runs_play_d);
    runs_total_d = sum[RUN_W] ? '1 : sum[RUN_W-1:0];
    walk_d = walk;
    inning_end_d = inning_end;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      runner_q <= '0;
      ball_cnt_q <= 3'd0;
      out_cnt_q <= 3'd0;
      runs_total_q <= '0;
      runs_play_q <= '0;
      walk_q <= 1'b0;
      inning_end_q <= 1'b0;
    end else begin
      runner_q <= runner_d;
      ball_cnt_q <= ball_cnt_d;
      out_cnt_q <= out_cnt_d;
      runs_total_q <= runs_total_d;
      runs_play_q <= runs_play_d;
      walk_q <= walk_d;
      inning_end_q <= inning_end_d;
    end
  end
  assign runner = runner_q;
  assign ball_cnt = ball_cnt_q;
  assign out_cnt = out_cnt_q;
  assign runs_total = runs_total_q;
  assign runs_play = runs_play_q;
  assign walk_p = walk_q;
  assign inning_end_p = inning_end_q;
endmodule

// File: tb/tb_base_runner_tracker.sv
// tb_base_runner_tracker: directed and random stimulus against a base-by-base model of the tracker
module tb_base_runner_tracker;
  localparam int NB = 3, BW = 4, OPI = 3, RW = 8;
  localparam int MAXT = (1 << RW) - 1;
  logic clk = 1'b0;
  logic rst, ball, single, double, triple, homerun, out_evt;
  logic [NB-1:0] runner;
  logic [2:0] ball_cnt, out_cnt, runs_play;
  logic [RW-1:0] runs_total;
  logic walk_p, inning_end_p;
  int checks = 0, failures = 0;
  int m_b[0:NB];
  int m_balls, m_outs, m_total, m_play;
  bit m_walk, m_ie;
  base_runner_tracker #(.NUM_BASES(NB), .BALLS_PER_WALK(BW), .OUTS_PER_INNING(OPI), .RUN_W(RW)) dut (
    .clk(clk), .rst(rst), .ball(ball), .single(single), .double(double), .triple(triple),
    .homerun(homerun), .out_evt(out_evt), .runner(runner), .ball_cnt(ball_cnt), .out_cnt(out_cnt),
    .runs_total(runs_total), .runs_play(runs_play), .walk_p(walk_p), .inning_end_p(inning_end_p)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int model_runner();
    int v = 0;
    for (int i = 1; i <= NB; i++) if (m_b[i] != 0) v += 1 << (i - 1);
    return v;
  endfunction
  task automatic model_step(input bit r, bl, s, d, t, h, o);
    int k, nb[0:NB], j;
    m_walk = 0;
    m_ie = 0;
    m_play = 0;
    if (r) begin
      for (int i = 0; i <= NB; i++) m_b[i] = 0;
      m_balls = 0; m_outs = 0; m_total = 0;
      return;
    end
    k = h ? NB + 1 : t ? 3 : d ? 2 : s ? 1 : 0;
    if (k > 0) begin
      for (int i = 0; i <= NB; i++) nb[i] = 0;
      m_b[0] = 1;
      for (int i = 0; i <= NB; i++)
        if (m_b[i] != 0) begin
          if (i + k > NB) m_play++;
          else nb[i + k] = 1;
        end
      for (int i = 0; i <= NB; i++) m_b[i] = nb[i];
      m_b[0] = 0;
      m_balls = 0;
    end else if (o) begin
      m_outs++;
      m_balls = 0;
      if (m_outs == OPI) begin
        for (int i = 0; i <= NB; i++) m_b[i] = 0;
        m_outs = 0;
        m_ie = 1;
      end
    end else if (bl) begin
      m_balls++;
      if (m_balls == BW) begin
        j = 1;
        while (j <= NB && m_b[j] != 0) j++;
        if (j > NB) m_play = 1;
        else m_b[j] = 1;
        m_balls = 0;
        m_walk = 1;
      end
    end
    m_total = (m_total + m_play > MAXT) ? MAXT : m_total + m_play;
  endtask
  task automatic compare_all();
    check("runner", int'(runner), model_runner());
    check("ball_cnt", int'(ball_cnt), m_balls);
    check("out_cnt", int'(out_cnt), m_outs);
    check("runs_total", int'(runs_total), m_total);
    check("runs_play", int'(runs_play), m_play);
    check("walk_p", int'(walk_p), int'(m_walk));
    check("inning_end_p", int'(inning_end_p), int'(m_ie));
  endtask
  task automatic step(input bit r, bl, s, d, t, h, o);
    rst = r; ball = bl; single = s; double = d; triple = t; homerun = h; out_evt = o;
    @(posedge clk);
    model_step(r, bl, s, d, t, h, o);
    #1;
    compare_all();
  endtask
  task automatic do_reset();   step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_ball();    step(0, 1, 0, 0, 0, 0, 0); endtask
  task automatic do_single();  step(0, 0, 1, 0, 0, 0, 0); endtask
  task automatic do_double();  step(0, 0, 0, 1, 0, 0, 0); endtask
  task automatic do_triple();  step(0, 0, 0, 0, 1, 0, 0); endtask
  task automatic do_homerun(); step(0, 0, 0, 0, 0, 1, 0); endtask
  task automatic do_out();     step(0, 0, 0, 0, 0, 0, 1); endtask
  int prev;
  initial begin
    for (int i = 0; i <= NB; i++) m_b[i] = 0;
    m_balls = 0; m_outs = 0; m_total = 0; m_play = 0; m_walk = 0; m_ie = 0;
    do_reset();
    do_reset();
    check("lit_reset_runner", int'(runner), 0);
    check("lit_reset_total", int'(runs_total), 0);
    do_triple();
    repeat (BW) do_ball();
    check("lit_walk_to_101", int'(runner), 5);
    prev = int'(runs_total);
    do_single();
    check("lit_single_runner", int'(runner), 3);
    check("lit_single_play", int'(runs_play), 1);
    check("lit_single_total", int'(runs_total), prev + 1);
    do_reset();
    do_double();
    do_single();
    do_double();
    check("lit_setup_110", int'(runner), 6);
    repeat (BW) do_ball();
    check("lit_walk110_runner", int'(runner), 7);
    check("lit_walk110_play", int'(runs_play), 0);
    repeat (BW - 1) do_ball();
    check("lit_walk_no_pulse_early", int'(walk_p), 0);
    do_ball();
    check("lit_loaded_walk_p", int'(walk_p), 1);
    check("lit_loaded_runner", int'(runner), 7);
    check("lit_loaded_play", int'(runs_play), 1);
    check("lit_loaded_balls", int'(ball_cnt), 0);
    do_reset();
    do_out();
    do_out();
    do_single();
    do_single();
    check("lit_pre_out_runner", int'(runner), 3);
    check("lit_pre_out_outs", int'(out_cnt), 2);
    prev = int'(runs_total);
    do_out();
    check("lit_inning_end_p", int'(inning_end_p), 1);
    check("lit_inning_runner", int'(runner), 0);
    check("lit_inning_outs", int'(out_cnt), 0);
    check("lit_inning_total", int'(runs_total), prev);
    do_reset();
    do_ball();
    step(0, 1, 1, 0, 0, 0, 0);
    check("lit_prio_runner", int'(runner), 1);
    check("lit_prio_balls", int'(ball_cnt), 0);
    step(1, 0, 0, 1, 0, 0, 0);
    check("lit_rst_double_runner", int'(runner), 0);
    check("lit_rst_double_play", int'(runs_play), 0);
    repeat (254) do_homerun();
    check("lit_total_254", int'(runs_total), 254);
    repeat (3) do_single();
    do_homerun();
    check("lit_hr_play", int'(runs_play), 4);
    check("lit_hr_runner", int'(runner), 0);
    check("lit_hr_sat", int'(runs_total), 255);
    do_homerun();
    check("lit_sat_hold", int'(runs_total), 255);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit r, bl, s, d, t, h, o;
      r = ($urandom_range(0, 199) == 0);
      bl = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 11) == 0);
      t = ($urandom_range(0, 19) == 0);
      h = ($urandom_range(0, 24) == 0);
      o = ($urandom_range(0, 5) == 0);
      step(r, bl, s, d, t, h, o);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/base_runner_tracker.md
BASE_RUNNER_TRACKER -- requirements
Module: base_runner_tracker

Interface
REQ-001 SHALL have parameter NUM_BASES, default 3, number of bases before home (2..7).
REQ-002 SHALL have parameter BALLS_PER_WALK, default 4, balls that award a walk (2..7).
REQ-003 SHALL have parameter OUTS_PER_INNING, default 3, outs that end a half-inning (1..7).
REQ-004 SHALL have parameter RUN_W, default 8, width of the run total.
REQ-005 SHALL have one clock and a synchronous, active-high reset, ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: ball  in  1  pitch called ball.
REQ-007 SHALL have ports: single, double, triple, homerun  in  1 each  hit events advancing batter 1/2/3/NUM_BASES+1 bases.
REQ-008 SHALL have port: out_evt  in  1  batter out, no runner advance.
REQ-009 SHALL have port: runner  out  NUM_BASES  occupancy, bit 0 = 1st base.
REQ-010 SHALL have ports: ball_cnt  out  3  balls on current batter; out_cnt  out  3  outs in half-inning.
REQ-011 SHALL have ports: runs_total  out  RUN_W  accumulated runs; runs_play  out  3  runs scored by last event.
REQ-012 SHALL have ports: walk_p, inning_end_p  out  1  one-cycle pulses.

Function
REQ-013 SHALL sample inputs on rising clk; all outputs registered, updating exactly one cycle after the event edge.
REQ-014 SHALL resolve simultaneous events by priority homerun > triple > double > single > out_evt > ball; lower-priority events are dropped.
REQ-015 SHALL on a hit of k bases: shift occupancy up by k, place batter at base k (bit k-1) if k <= NUM_BASES, score every runner and the batter passing home.
REQ-016 SHALL treat triple as a home-run-equivalent advance when NUM_BASES < 3, and double likewise when NUM_BASES < 2.
REQ-017 SHALL on a ball increment ball_cnt; when it reaches BALLS_PER_WALK, award a walk in the same update.
REQ-018 SHALL on a walk advance only forced runners: batter to 1st, each runner moves only if all bases below it are occupied; bases loaded scores exactly 1 run.
REQ-019 SHALL pulse walk_p for one cycle on a walk.
REQ-020 SHALL clear ball_cnt on any hit, walk or out.
REQ-021 SHALL on out_evt increment out_cnt; on reaching OUTS_PER_INNING clear runner, out_cnt and ball_cnt, pulse inning_end_p, score 0.
REQ-022 SHALL set runs_play to the runs of the latest event, and to 0 on cycles with no event.
REQ-023 SHALL add runs_play to runs_total, saturating at 2^RUN_W-1 (no wrap).
REQ-024 SHALL leave runs_total unchanged across inning end.
REQ-025 SHALL perform state update with no combinational loop; no latches.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set runner=0, ball_cnt=0, out_cnt=0, runs_total=0, runs_play=0, walk_p=0, inning_end_p=0.
REQ-027 SHALL give rst priority over every event in the same cycle, discarding those events.
REQ-028 SHALL take the first event one cycle after rst deasserts.

Structure
REQ-029 SHALL place event-priority encoding constants, default parameter values and the runs_play width in shared package runner_pkg.
REQ-030 SHALL implement the advance/score computation (occupancy in, advance count, force mode in -> occupancy out, runs out) as combinational sub-module base_advance.
REQ-031 SHALL keep all registers in base_runner_tracker; the target size is 120-400 lines of RTL.

Verification (NUM_BASES=3 defaults)
REQ-032 SHALL cover: runner=101, single -> runner=011, runs_play=1, runs_total+1.
REQ-033 SHALL cover: runner=111, four balls -> walk_p on the 4th, runner=111, runs_play=1, ball_cnt=0.
REQ-034 SHALL cover: runner=110, walk -> runner=111, runs_play=0 (no forced advance).
REQ-035 SHALL cover: runner=111, homerun -> runner=000, runs_play=4; runs_total=254 then +4 -> 255 saturated.
REQ-036 SHALL cover: out_cnt=2, runner=011, out_evt -> inning_end_p, runner=000, out_cnt=0, runs_total unchanged.
REQ-037 SHALL cover: single+ball same cycle -> single only, ball_cnt=0; rst with double same cycle -> all outputs 0.
